// File: rtl/mem_ctrl_pkg.sv
// Shared widths, size encodings and state type for the byte-serial memory controller.
// Included by mem_ctrl and by anything that needs the IO map or access-size codes.
package mem_ctrl_pkg;

    localparam int ADDR_TYPE = 32;
    localparam int INST_TYPE = 32;
    localparam int DATA_TYPE = 32;

    typedef logic [ADDR_TYPE-1:0] addr_t;
    typedef logic [INST_TYPE-1:0] inst_t;
    typedef logic [DATA_TYPE-1:0] data_t;

    localparam addr_t ZERO_ADDR = '0;
    localparam data_t ZERO_WORD = '0;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam addr_t IO_BASE = 32'h0003_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } status_t;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    // Sub-word loads spend one turnaround cycle after their last byte so that
    // load latency is 4 + size; a full word finishes on its last capture.
    function automatic logic [2:0] read_last_k(input logic [2:0] n);
        return (n == 3'd4) ? 3'd4 : n + 3'd1;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: serves fetch queries and LSB loads/stores as byte-serial
// accesses on the 8-bit synchronous RAM/IO port; LSB wins over fetch when both wait.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = mem_ctrl_pkg::IO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        start_query_signal,
    input  logic [31:0] query_pc,
    output logic        finish_query_signal,
    output logic [31:0] queried_inst,
    input  logic        lsb_start,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_finish,
    output logic [31:0] lsb_rdata,
    input  logic        misbranch_flag
);
    import mem_ctrl_pkg::*;

    status_t    state_q, state_d;

    logic       f_pend_q, f_pend_d;
    addr_t      f_pc_q, f_pc_d;

    logic       l_pend_q, l_pend_d;
    logic       l_wr_q, l_wr_d;
    logic [1:0] l_size_q, l_size_d;
    addr_t      l_addr_q, l_addr_d;
    data_t      l_wdata_q, l_wdata_d;

    logic       cur_lsb_q, cur_lsb_d;
    addr_t      cur_base_q, cur_base_d;
    logic [2:0] cur_n_q, cur_n_d;
    logic [2:0] k_q, k_d;
    data_t      buf_q, buf_d;

    addr_t      mem_a_q, mem_a_d;
    logic [7:0] mem_dout_q, mem_dout_d;
    logic       mem_wr_q, mem_wr_d;

    logic       fin_fetch_q, fin_fetch_d;
    logic       fin_lsb_q, fin_lsb_d;
    inst_t      inst_q, inst_d;
    data_t      rdata_q, rdata_d;

    logic       io_stall;
    logic [2:0] k_nxt;
    logic [1:0] lane;

    assign io_stall = (state_q == ST_WRITE) && (mem_a_q >= IO_BASE) && io_buffer_full;
    assign k_nxt    = k_q + 3'd1;
    assign lane     = k_q[1:0] - 2'd1;

    always_comb begin
        state_d     = state_q;
        f_pend_d    = f_pend_q && !misbranch_flag;
        f_pc_d      = f_pc_q;
        l_pend_d    = l_pend_q && !(misbranch_flag && !l_wr_q);
        l_wr_d      = l_wr_q;
        l_size_d    = l_size_q;
        l_addr_d    = l_addr_q;
        l_wdata_d   = l_wdata_q;
        cur_lsb_d   = cur_lsb_q;
        cur_base_d  = cur_base_q;
        cur_n_d     = cur_n_q;
        k_d         = k_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        fin_fetch_d = 1'b0;
        fin_lsb_d   = 1'b0;
        inst_d      = inst_q;
        rdata_d     = rdata_q;

        // A fetch arriving together with a flush belongs to the new path and survives it.
        if (start_query_signal) begin
            f_pend_d = 1'b1;
            f_pc_d   = query_pc;
        end
        if (lsb_start) begin
            l_pend_d  = 1'b1;
            l_wr_d    = lsb_wr;
            l_size_d  = lsb_size;
            l_addr_d  = lsb_addr;
            l_wdata_d = lsb_wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (l_pend_d) begin
                    l_pend_d   = 1'b0;
                    cur_lsb_d  = 1'b1;
                    cur_base_d = l_addr_d;
                    cur_n_d    = byte_count(l_size_d);
                    k_d        = 3'd0;
                    buf_d      = ZERO_WORD;
                    mem_a_d    = l_addr_d;
                    if (l_wr_d) begin
                        state_d    = ST_WRITE;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = l_wdata_d[7:0];
                    end else begin
                        state_d    = ST_READ;
                    end
                end else if (f_pend_d) begin
                    f_pend_d   = 1'b0;
                    cur_lsb_d  = 1'b0;
                    cur_base_d = f_pc_d;
                    cur_n_d    = 3'd4;
                    k_d        = 3'd0;
                    buf_d      = ZERO_WORD;
                    mem_a_d    = f_pc_d;
                    state_d    = ST_READ;
                end
            end

            ST_READ: begin
                if (misbranch_flag) begin
                    state_d = ST_IDLE;
                end else begin
                    // mem_din carries the byte addressed one cycle earlier.
                    if (k_q != 3'd0 && k_q <= cur_n_q) begin
                        buf_d[{lane, 3'b000} +: 8] = mem_din;
                    end
                    if (k_q == read_last_k(cur_n_q)) begin
                        state_d = ST_IDLE;
                        if (cur_lsb_q) begin
                            fin_lsb_d = 1'b1;
                            rdata_d   = buf_d;
                        end else begin
                            fin_fetch_d = 1'b1;
                            inst_d      = buf_d;
                        end
                    end else begin
                        k_d = k_nxt;
                        if (k_nxt < cur_n_q) begin
                            mem_a_d = cur_base_q + {29'd0, k_nxt};
                        end
                    end
                end
            end

            ST_WRITE: begin
                if (!io_stall) begin
                    if (k_q == cur_n_q - 3'd1) begin
                        state_d   = ST_IDLE;
                        mem_wr_d  = 1'b0;
                        fin_lsb_d = 1'b1;
                    end else begin
                        k_d        = k_nxt;
                        mem_a_d    = cur_base_q + {29'd0, k_nxt};
                        mem_dout_d = l_wdata_q[{k_nxt[1:0], 3'b000} +: 8];
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            f_pend_q    <= 1'b0;
            f_pc_q      <= ZERO_ADDR;
            l_pend_q    <= 1'b0;
            l_wr_q      <= 1'b0;
            l_size_q    <= SIZE_BYTE;
            l_addr_q    <= ZERO_ADDR;
            l_wdata_q   <= ZERO_WORD;
            cur_lsb_q   <= 1'b0;
            cur_base_q  <= ZERO_ADDR;
            cur_n_q     <= 3'd0;
            k_q         <= 3'd0;
            buf_q       <= ZERO_WORD;
            mem_a_q     <= ZERO_ADDR;
            mem_dout_q  <= 8'h00;
            mem_wr_q    <= 1'b0;
            fin_fetch_q <= 1'b0;
            fin_lsb_q   <= 1'b0;
            inst_q      <= ZERO_WORD;
            rdata_q     <= ZERO_WORD;
        end else if (rdy) begin
            state_q     <= state_d;
            f_pend_q    <= f_pend_d;
            f_pc_q      <= f_pc_d;
            l_pend_q    <= l_pend_d;
            l_wr_q      <= l_wr_d;
            l_size_q    <= l_size_d;
            l_addr_q    <= l_addr_d;
            l_wdata_q   <= l_wdata_d;
            cur_lsb_q   <= cur_lsb_d;
            cur_base_q  <= cur_base_d;
            cur_n_q     <= cur_n_d;
            k_q         <= k_d;
            buf_q       <= buf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            fin_fetch_q <= fin_fetch_d;
            fin_lsb_q   <= fin_lsb_d;
            inst_q      <= inst_d;
            rdata_q     <= rdata_d;
        end
    end

    // Write strobe drops immediately on a global pause or a full IO buffer.
    assign mem_wr              = mem_wr_q && rdy && !io_stall;
    assign mem_a               = mem_a_q;
    assign mem_dout            = mem_dout_q;
    assign finish_query_signal = fin_fetch_q;
    assign queried_inst        = inst_q;
    assign lsb_finish          = fin_lsb_q;
    assign lsb_rdata           = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized single/colliding requests
// checked against a transaction-level model of memory contents and latencies.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;
    logic        start_query_signal, finish_query_signal;
    logic [31:0] query_pc, queried_inst;
    logic        lsb_start, lsb_wr, lsb_finish, misbranch_flag;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .start_query_signal(start_query_signal), .query_pc(query_pc),
        .finish_query_signal(finish_query_signal), .queried_inst(queried_inst),
        .lsb_start(lsb_start), .lsb_wr(lsb_wr), .lsb_size(lsb_size),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_finish(lsb_finish), .lsb_rdata(lsb_rdata),
        .misbranch_flag(misbranch_flag)
    );

    always #5 clk = ~clk;

    // 4 KiB synchronous RAM; address bits above 11 alias, IO space included.
    logic [7:0] ram       [0:4095];
    logic [7:0] model_mem [0:4095];

    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
            mem_din <= ram[mem_a[11:0]];
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] a_log    [0:39];
    logic        wr_log   [0:39];
    logic [7:0]  dout_log [0:39];
    int          fq_cyc[$];
    logic [31:0] fq_dat[$];
    int          lq_cyc[$];
    logic [31:0] lq_dat[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        logic [31:0] ai;
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            v[8*i +: 8] = model_mem[ai[11:0]];
        end
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] d);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            model_mem[ai[11:0]] = d[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [31:0] v;
        logic [31:0] ai;
        for (int i = 0; i < 4; i++) begin
            ai = a + 32'(i);
            v[8*i +: 8] = ram[ai[11:0]];
        end
        return v;
    endfunction

    function automatic logic [31:0] first_or_none(input int q[$]);
        return (q.size() > 0) ? 32'(q[0]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] first_dat(input logic [31:0] q[$]);
        return (q.size() > 0) ? q[0] : 32'hDEAD_0000;
    endfunction

    // Cycle 0 carries the request pulses; 35 further cycles are logged.
    task automatic run_req(input bit f_on, input logic [31:0] f_pc,
                           input bit l_on, input bit l_w, input logic [1:0] l_sz,
                           input logic [31:0] l_a, input logic [31:0] l_wd,
                           input int rdy_at, input int rdy_len, input int io_len,
                           input int mb_at, input int f2_at, input logic [31:0] f2_pc);
        fq_cyc.delete(); fq_dat.delete(); lq_cyc.delete(); lq_dat.delete();
        start_query_signal = f_on; query_pc = f_pc;
        lsb_start = l_on; lsb_wr = l_w; lsb_size = l_sz; lsb_addr = l_a; lsb_wdata = l_wd;
        misbranch_flag = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        for (int c = 1; c < 36; c++) begin
            tick();
            lsb_start = 1'b0;
            if (c == f2_at) begin
                start_query_signal = 1'b1;
                query_pc = f2_pc;
            end else begin
                start_query_signal = 1'b0;
            end
            misbranch_flag = (c == mb_at);
            rdy = !(c >= rdy_at && c < rdy_at + rdy_len);
            io_buffer_full = (c >= 1 && c <= io_len);
            #1;
            a_log[c] = mem_a; wr_log[c] = mem_wr; dout_log[c] = mem_dout;
            if (rdy && finish_query_signal) begin fq_cyc.push_back(c); fq_dat.push_back(queried_inst); end
            if (rdy && lsb_finish) begin lq_cyc.push_back(c); lq_dat.push_back(lsb_rdata); end
        end
        start_query_signal = 1'b0; misbranch_flag = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w, addr, pc, wd;
        int kind, sz, n, h, io_len, stall, mb, exp_l, exp_f;
        bit has_f, has_l, is_st;

        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            model_mem[i] = ram[i];
        end
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'hA0; ram[12'h103] = 8'h00;
        for (int i = 12'h100; i < 12'h104; i++) model_mem[i] = ram[i];

        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; misbranch_flag = 1'b0;
        start_query_signal = 1'b0; query_pc = 32'h0;
        lsb_start = 1'b0; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h0; lsb_wdata = 32'h0;
        repeat (3) tick();
        check_val("rst_mem_a", mem_a, 32'h0);
        check_val("rst_mem_wr", 32'(mem_wr), 32'h0);
        check_val("rst_mem_dout", 32'(mem_dout), 32'h0);
        check_val("rst_fin_q", 32'(finish_query_signal), 32'h0);
        check_val("rst_inst", queried_inst, 32'h0);
        check_val("rst_lsb_fin", 32'(lsb_finish), 32'h0);
        check_val("rst_rdata", lsb_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Plain fetch
        run_req(1, 32'h100, 0, 0, 2'd0, 0, 0, 0, 0, 0, -1, -1, 0);
        for (int i = 1; i <= 4; i++) check_val("fetch_addr", a_log[i], 32'h100 + 32'(i - 1));
        check_val("fetch_cnt", 32'(fq_cyc.size()), 32'd1);
        check_val("fetch_cyc", first_or_none(fq_cyc), 32'd6);
        check_val("fetch_data", first_dat(fq_dat), 32'h00A00513);

        // Fetch and load collide: load first, fetch back-to-back
        exp_w = model_read(32'h200, 4);
        run_req(1, 32'h300, 1, 0, 2'd2, 32'h200, 0, 0, 0, 0, -1, -1, 0);
        check_val("coll_lcyc", first_or_none(lq_cyc), 32'd6);
        check_val("coll_ldata", first_dat(lq_dat), exp_w);
        check_val("coll_faddr", a_log[7], 32'h300);
        check_val("coll_fcyc", first_or_none(fq_cyc), 32'd12);
        check_val("coll_fdata", first_dat(fq_dat), model_read(32'h300, 4));

        // Store half
        model_write(32'h40, 2, 32'hDEADBEEF);
        run_req(0, 0, 1, 1, 2'd1, 32'h40, 32'hDEADBEEF, 0, 0, 0, -1, -1, 0);
        check_val("sth_wr1", 32'(wr_log[1]), 32'd1);
        check_val("sth_a1", a_log[1], 32'h40);
        check_val("sth_d1", 32'(dout_log[1]), 32'hEF);
        check_val("sth_a2", a_log[2], 32'h41);
        check_val("sth_d2", 32'(dout_log[2]), 32'hBE);
        check_val("sth_cyc", first_or_none(lq_cyc), 32'd3);
        check_val("sth_wr3", 32'(wr_log[3]), 32'd0);
        check_val("sth_ram", ram_word(32'h40), model_read(32'h40, 4));

        // IO store stalled by a full buffer
        model_write(32'h30004, 1, 32'h5A);
        run_req(0, 0, 1, 1, 2'd0, 32'h30004, 32'h5A, 0, 0, 3, -1, -1, 0);
        for (int i = 1; i <= 3; i++) check_val("io_stall_wr", 32'(wr_log[i]), 32'd0);
        check_val("io_wr4", 32'(wr_log[4]), 32'd1);
        check_val("io_d4", 32'(dout_log[4]), 32'h5A);
        check_val("io_cyc", first_or_none(lq_cyc), 32'd5);
        check_val("io_ram", ram_word(32'h30004), model_read(32'h30004, 4));

        // Flush aborts the fetch; a new fetch one cycle later completes normally
        run_req(1, 32'h100, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3, 4, 32'h80);
        check_val("flush_cnt", 32'(fq_cyc.size()), 32'd1);
        check_val("flush_cyc", first_or_none(fq_cyc), 32'd10);
        check_val("flush_data", first_dat(fq_dat), model_read(32'h80, 4));

        // Fetch arriving with the flush is kept
        run_req(1, 32'h100, 0, 0, 2'd0, 0, 0, 0, 0, 0, 3, 3, 32'h84);
        check_val("flush_same_cnt", 32'(fq_cyc.size()), 32'd1);
        check_val("flush_same_cyc", first_or_none(fq_cyc), 32'd10);
        check_val("flush_same_data", first_dat(fq_dat), model_read(32'h84, 4));

        // rdy low for two cycles mid-read
        run_req(1, 32'h100, 0, 0, 2'd0, 0, 0, 2, 2, 0, -1, -1, 0);
        check_val("rdy_wr2", 32'(wr_log[2]), 32'd0);
        check_val("rdy_wr3", 32'(wr_log[3]), 32'd0);
        check_val("rdy_a3", a_log[3], 32'h101);
        check_val("rdy_a4", a_log[4], 32'h101);
        check_val("rdy_cyc", first_or_none(fq_cyc), 32'd8);
        check_val("rdy_data", first_dat(fq_dat), 32'h00A00513);

        // Randomized: 0 fetch, 1 load, 2 store, 3 fetch+load, 4 fetch+store
        for (int t = 0; t < 60; t++) begin
            kind  = $urandom_range(0, 4);
            sz    = $urandom_range(0, 2);
            n     = 1 << sz;
            has_f = (kind == 0) || (kind >= 3);
            has_l = (kind != 0);
            is_st = (kind == 2) || (kind == 4);
            addr  = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            if (is_st && $urandom_range(0, 2) == 0) addr = 32'h30000 + 32'($urandom_range(0, 255));
            pc     = 32'($urandom_range(0, 4095));
            wd     = $urandom;
            h      = is_st ? 0 : $urandom_range(0, 2);
            io_len = $urandom_range(0, 3);
            stall  = (is_st && addr >= 32'h30000) ? io_len : 0;
            mb     = (kind == 2 && $urandom_range(0, 1) == 1) ? 1 : -1;

            if (is_st) begin
                exp_l = n + 1 + stall;
                model_write(addr, n, wd);
            end else begin
                exp_l = 4 + sz + h;
            end
            exp_f = (kind == 0) ? 6 + h : exp_l + 6;

            run_req(has_f, pc, has_l, is_st, 2'(sz), addr, wd, 2, h, io_len, mb, -1, 0);

            if (has_l) begin
                check_val("rnd_lcnt", 32'(lq_cyc.size()), 32'd1);
                check_val("rnd_lcyc", first_or_none(lq_cyc), 32'(exp_l));
                if (is_st) check_val("rnd_ram", ram_word(addr), model_read(addr, 4));
                else       check_val("rnd_ldata", first_dat(lq_dat), model_read(addr, n));
            end
            if (has_f) begin
                check_val("rnd_fcnt", 32'(fq_cyc.size()), 32'd1);
                check_val("rnd_fcyc", first_or_none(fq_cyc), 32'(exp_f));
                check_val("rnd_fdata", first_dat(fq_dat), model_read(pc, 4));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
